reorder_buffer: RTL
===================

// Module: reorder_buffer
// PURPOSE
//  In-order retirement buffer between rename/dispatch and commit_unit in the OoO core.
//  Dispatch allocates one entry per renamed instr (dest v_reg, new p_reg, previous p_reg).
//  Execution marks entries complete by tag, out of order. The oldest completed entry is
//  presented to commit_unit, which updates architectural state and frees the old p_reg.
// PARAMETERS
//  DEPTH   16                 entries; power of 2, >=2
//  PREG_W  $clog2(`NUM_REG)   physical register address width
//  VREG_W  4                  virtual (architectural) register width; 16 regs
// PORTS
//  clk               in   1          clock; one clock domain
//  n_rst             in   1          reset; asynchronous, active-high (1 = in reset)
//  alloc_valid       in   1          dispatch presents an instr
//  alloc_ready       out  1          entry available (!full)
//  alloc_dest_valid  in   1          instr writes a register
//  alloc_v_reg       in   VREG_W     dest virtual reg
//  alloc_p_reg       in   PREG_W     newly mapped physical reg
//  alloc_old_p_reg   in   PREG_W     previous mapping; freed at commit
//  alloc_tag         out  log2 DEPTH tag of entry allocated this cycle (= tail index)
//  complete_valid    in   1          execution reports completion
//  complete_tag      in   log2 DEPTH entry completing
//  commit_valid      out  1          head entry valid and complete
//  commit_ready      in   1          commit_unit accepts head
//  commit_dest_valid out  1          head entry fields ...
//  commit_v_reg      out  VREG_W
//  commit_p_reg      out  PREG_W
//  commit_old_p_reg  out  PREG_W
//  flush             in   1          discard all entries (mispredict/interrupt)
//  count             out  log2 DEPTH+1 occupied entries
// BEHAVIOUR
//  - One clock; reset is asynchronous and active-high.
//  - Reset: head=tail=0 (each with extra wrap bit), all valid/done bits 0, count=0;
//    alloc_ready=1, commit_valid=0, alloc_tag=0; commit_* data outputs 0.
//  - Circular buffer; full = idx equal & wrap bits differ; empty = pointers equal.
//  - alloc_ready = !full from registered state; no same-cycle bypass of a commit.
//  - Alloc on alloc_valid&alloc_ready: write entry at tail, valid=1, done=0, tail+1.
//    alloc_valid while !alloc_ready: ignored, no state change.
//  - Complete on complete_valid: set done[complete_tag] the next edge. Tag not valid or
//    already done: ignored (bench flags as error). Entry allocated in cycle N can
//    complete in N+1 or later.
//  - commit_valid = valid[head] & done[head] (registered state).
//    Commit on commit_valid&commit_ready: valid[head]=0, head+1. Max 1 commit/cycle.
//  - Same cycle alloc+commit: both occur; count unchanged. Index wraps DEPTH-1 -> 0 with
//    the wrap bit toggled.
//  - Flush: synchronous, highest priority; all valid/done cleared, head=tail=0, count=0.
//    Alloc/complete/commit in the flush cycle are discarded.
//  - Reset asserted mid-operation: immediate return to reset values, regardless of clk.
//  - count: +1 on alloc, -1 on commit; range 0..DEPTH.
// CONFIGURATION
//  ROB_COMPLETE_BYPASS_EN defined: commit_valid also asserts when head is valid and
//    complete_valid & complete_tag==head in the same cycle (commit in completion cycle).
//  Undefined: commit_valid only from registered done; earliest commit is the cycle after
//    completion.
// TESTING
//  1 reset, no stimulus -> alloc_ready=1, commit_valid=0, count=0, alloc_tag=0.
//  2 alloc 3 instrs (p_reg 5,6,7), complete tags 2,0,1 -> commits in order 0,1,2 with
//    commit_p_reg 5,6,7; commit of tag 0 waits until tag 0 completes.
//  3 alloc 16 with no commit -> count=16, alloc_ready=0; 17th alloc ignored. Complete and
//    commit 1 -> alloc_ready=1 next cycle, next alloc_tag=0 (wrap).
//  4 full ROB, head done, alloc_valid & commit_ready same cycle -> commit only;
//    non-full, alloc+commit same cycle -> count unchanged.
//  5 8 entries, flush with alloc_valid=1 -> next cycle count=0, commit_valid=0, alloc_tag=0.
//  6 complete head tag, commit_ready=1 -> commit_valid same cycle with
//    ROB_COMPLETE_BYPASS_EN, one cycle later without.

Source files
------------

// File: rtl/reorder_buffer.sv
// rtl/reorder_buffer.sv - in-order retirement buffer with out-of-order completion by tag.
// Optional ROB_COMPLETE_BYPASS_EN: a completing head entry may commit in its completion cycle.
`ifndef NUM_REG
`define NUM_REG 64
`endif

module reorder_buffer #(
    parameter int DEPTH  = 16,
    parameter int PREG_W = $clog2(`NUM_REG),
    parameter int VREG_W = 4
) (
    input  logic                       clk,
    input  logic                       n_rst,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic                       alloc_dest_valid,
    input  logic [VREG_W-1:0]          alloc_v_reg,
    input  logic [PREG_W-1:0]          alloc_p_reg,
    input  logic [PREG_W-1:0]          alloc_old_p_reg,
    output logic [$clog2(DEPTH)-1:0]   alloc_tag,
    input  logic                       complete_valid,
    input  logic [$clog2(DEPTH)-1:0]   complete_tag,
    output logic                       commit_valid,
    input  logic                       commit_ready,
    output logic                       commit_dest_valid,
    output logic [VREG_W-1:0]          commit_v_reg,
    output logic [PREG_W-1:0]          commit_p_reg,
    output logic [PREG_W-1:0]          commit_old_p_reg,
    input  logic                       flush,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [IDX_W:0]     head_q, head_d, tail_q, tail_d, count_q, count_d;
    logic [DEPTH-1:0]   valid_q, valid_d, done_q, done_d;
    logic               dest_q  [DEPTH];
    logic [VREG_W-1:0]  v_reg_q [DEPTH];
    logic [PREG_W-1:0]  p_reg_q [DEPTH];
    logic [PREG_W-1:0]  old_q   [DEPTH];

    logic [IDX_W-1:0]   head_idx, tail_idx;
    logic               full, head_done, complete_hit, do_alloc, do_commit;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign full     = (head_idx == tail_idx) && (head_q[IDX_W] != tail_q[IDX_W]);

`ifdef ROB_COMPLETE_BYPASS_EN
    assign head_done = done_q[head_idx] || (complete_valid && complete_tag == head_idx);
`else
    assign head_done = done_q[head_idx];
`endif

    // Completions for free or already-done slots are dropped.
    assign complete_hit = complete_valid && valid_q[complete_tag] && !done_q[complete_tag];

    assign alloc_ready  = !full;
    assign commit_valid = valid_q[head_idx] && head_done;
    assign do_alloc     = alloc_valid && alloc_ready;
    assign do_commit    = commit_valid && commit_ready;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        valid_d = valid_q;
        done_d  = done_q;
        count_d = count_q + (IDX_W+1)'(do_alloc) - (IDX_W+1)'(do_commit);
        if (complete_hit) begin
            done_d[complete_tag] = 1'b1;
        end
        if (do_commit) begin
            valid_d[head_idx] = 1'b0;
            done_d[head_idx]  = 1'b0;
            head_d            = head_q + 1'b1;
        end
        if (do_alloc) begin
            valid_d[tail_idx] = 1'b1;
            done_d[tail_idx]  = 1'b0;
            tail_d            = tail_q + 1'b1;
        end
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            valid_d = '0;
            done_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or posedge n_rst) begin
        if (n_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            count_q <= count_d;
        end
    end

    // Payload needs no reset: outputs are gated by the head valid bit.
    always_ff @(posedge clk) begin
        if (do_alloc && !flush) begin
            dest_q[tail_idx]  <= alloc_dest_valid;
            v_reg_q[tail_idx] <= alloc_v_reg;
            p_reg_q[tail_idx] <= alloc_p_reg;
            old_q[tail_idx]   <= alloc_old_p_reg;
        end
    end

    assign commit_dest_valid = valid_q[head_idx] && dest_q[head_idx];
    assign commit_v_reg      = {VREG_W{valid_q[head_idx]}} & v_reg_q[head_idx];
    assign commit_p_reg      = {PREG_W{valid_q[head_idx]}} & p_reg_q[head_idx];
    assign commit_old_p_reg  = {PREG_W{valid_q[head_idx]}} & old_q[head_idx];
    assign alloc_tag         = tail_idx;
    assign count             = count_q;

endmodule
